// File: rtl/lvds_comma_aligner_pkg.sv
// Shared 8b/10b comma constants and aligner state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lvds_comma_aligner_pkg;

  // K28.5 in both running disparities, bit 9 = code bit 'a'
  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // A disparity flip is not an error: either polarity is a comma
  function automatic logic is_k28_5(input logic [9:0] sym);
    return (sym == K28_5_RDN) || (sym == K28_5_RDP);
  endfunction

endpackage

// File: rtl/lvds_comma_detect.sv
// Finds K28.5 at any of the 10 bit offsets of a 20-bit window, lowest offset wins.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, the caller qualifies with its valid.
module lvds_comma_detect
  import lvds_comma_aligner_pkg::*;
(
  input  logic [19:0] win,
  output logic        hit,
  output logic [3:0]  hit_off
);

  logic [9:0] match;

  // One comparator per candidate; candidate k starts k bits into the window
  always_comb begin
    match = '0;
    for (int k = 0; k < 10; k++) begin
      match[k] = is_k28_5(win[19-k -: 10]);
    end
  end

  // Priority encode, scanning downwards so the lowest matching offset is kept
  always_comb begin
    hit     = 1'b0;
    hit_off = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (match[k]) begin
        hit     = 1'b1;
        hit_off = 4'(k);
      end
    end
  end

endmodule

// File: rtl/lvds_comma_aligner.sv
// Word aligner: locks onto the K28.5 bit offset and emits aligned 10-bit symbols.
// Latency: 1 cycle from a valid rx word to dout.
// Backpressure: none; rx_valid=0 freezes all state and blanks dout_valid/dout_comma.
module lvds_comma_aligner
  import lvds_comma_aligner_pkg::*;
#(
  parameter int LOCK_HITS      = 4,
  parameter int LOSS_HITS      = 3,
  parameter int VERIFY_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [9:0] dout,
  output logic       dout_valid,
  output logic       dout_comma,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int HIT_W  = $clog2(LOCK_HITS + 1);
  localparam int MISS_W = $clog2(LOSS_HITS + 1);
  localparam int TMO_W  = $clog2(VERIFY_TIMEOUT + 1);

  localparam logic [HIT_W-1:0]  HIT_LOCK  = HIT_W'(LOCK_HITS);
  localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_HITS);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(VERIFY_TIMEOUT);

  state_t            state, state_nxt;
  logic [9:0]        prev_q;
  logic [19:0]       win;
  logic              det_hit;
  logic [3:0]        det_off;
  logic [3:0]        cand, cand_nxt, offset_nxt;
  logic [HIT_W-1:0]  hit_cnt, hit_nxt, hit_inc;
  logic [MISS_W-1:0] miss_cnt, miss_nxt, miss_inc;
  logic [TMO_W-1:0]  tmo, tmo_nxt, tmo_inc;
  logic [3:0]        act_off;
  logic [9:0]        act_sym;
  logic              out_vld;

  assign win = {prev_q, rx_data};

  lvds_comma_detect u_detect (
    .win     (win),
    .hit     (det_hit),
    .hit_off (det_off)
  );

  // Saturating increments so no counter can wrap back to a small value
  assign hit_inc  = (hit_cnt  == HIT_LOCK)  ? hit_cnt  : hit_cnt  + 1'b1;
  assign miss_inc = (miss_cnt == MISS_LOSS) ? miss_cnt : miss_cnt + 1'b1;
  assign tmo_inc  = (tmo      == TMO_MAX)   ? tmo      : tmo      + 1'b1;

  // Symbol selection follows the candidate until lock, then the locked offset
  assign act_off = (state == ST_LOCKED) ? offset : cand;
  assign act_sym = 10'(win >> (4'd10 - act_off));
  assign out_vld = rx_valid && (state == ST_LOCKED);
  assign locked  = (state == ST_LOCKED);

  // Hit/miss lock qualification; only a valid word can move the FSM
  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    offset_nxt = offset;
    hit_nxt    = hit_cnt;
    miss_nxt   = miss_cnt;
    tmo_nxt    = tmo;
    if (rx_valid) begin
      case (state)
        ST_HUNT: begin
          if (det_hit) begin
            cand_nxt = det_off;
            hit_nxt  = HIT_W'(1);
            tmo_nxt  = '0;
            miss_nxt = '0;
            if (LOCK_HITS <= 1) begin
              state_nxt  = ST_LOCKED;
              offset_nxt = det_off;
            end else begin
              state_nxt = ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (det_hit && (det_off == cand)) begin
            hit_nxt = hit_inc;
            if (hit_inc == HIT_LOCK) begin
              state_nxt  = ST_LOCKED;
              offset_nxt = cand;
              miss_nxt   = '0;
            end
          end else if (det_hit) begin
            // A comma elsewhere restarts qualification at the new offset
            cand_nxt = det_off;
            hit_nxt  = HIT_W'(1);
            tmo_nxt  = '0;
          end else begin
            tmo_nxt = tmo_inc;
            if (tmo_inc == TMO_MAX) begin
              state_nxt = ST_HUNT;
              hit_nxt   = '0;
              tmo_nxt   = '0;
            end
          end
        end
        ST_LOCKED: begin
          // Data words never count against lock; only foreign commas do
          if (det_hit && (det_off == offset)) begin
            miss_nxt = '0;
          end else if (det_hit) begin
            miss_nxt = miss_inc;
            if (miss_inc == MISS_LOSS) begin
              state_nxt = ST_HUNT;
              miss_nxt  = '0;
              hit_nxt   = '0;
              tmo_nxt   = '0;
            end
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  // FSM state, candidate/offset and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HUNT;
      cand     <= 4'd0;
      offset   <= 4'd0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      tmo      <= '0;
    end else begin
      state    <= state_nxt;
      cand     <= cand_nxt;
      offset   <= offset_nxt;
      hit_cnt  <= hit_nxt;
      miss_cnt <= miss_nxt;
      tmo      <= tmo_nxt;
    end
  end

  // Previous word forms the upper half of the alignment window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 10'h000;
    end else if (rx_valid) begin
      prev_q <= rx_data;
    end
  end

  // Registered aligned symbol; flags blank on invalid cycles, dout holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= 10'h000;
      dout_valid <= 1'b0;
      dout_comma <= 1'b0;
    end else begin
      dout_valid <= out_vld;
      dout_comma <= out_vld && is_k28_5(act_sym);
      if (rx_valid) begin
        dout <= act_sym;
      end
    end
  end

endmodule

// File: tb/tb_lvds_comma_aligner.sv
// Directed bench for the comma aligner: symbol stream shifted by a chosen bit slip.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: rx_valid gaps exercised by table rows with vld=0.
module tb_lvds_comma_aligner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [9:0] dout;
  logic       dout_valid;
  logic       dout_comma;
  logic       locked;
  logic [3:0] offset;

  always #50 clk = ~clk;

  lvds_comma_aligner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_comma (dout_comma),
    .locked     (locked),
    .offset     (offset)
  );

  int errors = 0;
  int checks = 0;

  int         k_sh;      // bit slip applied to the transmitted symbol stream
  logic [9:0] last;      // previous transmitted symbol
  logic [9:0] det;       // symbol the aligner sees complete at the current word
  logic [9:0] cm;        // running comma, alternates disparity

  typedef struct {
    logic [9:0] sym;
    logic       vld;
    logic       exp_lk;
    logic [3:0] exp_off;
    logic       exp_dv;
    logic       exp_dc;
    logic       chk_dout;
    logic [9:0] exp_dout;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_comma(input logic [9:0] s);
    return (s == 10'h0FA) || (s == 10'h305);
  endfunction

  // Comma-free payload code group: each bit sent as a bit/inverse pair
  function automatic logic [9:0] man(input logic [7:0] b);
    logic [9:0] s;
    for (int i = 0; i < 5; i++) begin
      s[2*i+1] = b[i];
      s[2*i]   = ~b[i];
    end
    return s;
  endfunction

  function automatic logic [7:0] frame_byte(input int i);
    if (i == 0) return 8'hEE;
    if (i == 1) return 8'h33;
    return 8'(8'h34 + i - 2);
  endfunction

  // Present one word; an invalid word carries the raw symbol as junk
  task automatic send(input logic [9:0] sym, input logic vld);
    logic [19:0] pair;
    pair     = {last, sym};
    pair     = pair >> k_sh;
    rx_valid = vld;
    rx_data  = vld ? pair[9:0] : sym;
    if (vld) begin
      det  = last;
      last = sym;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_comma();
    send(cm, 1'b1);
    cm = ~cm;
  endtask

  task automatic do_reset(input int k);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 10'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.dout", 32'(dout), 32'h0);
    chk("rst.dout_valid", 32'(dout_valid), 32'h0);
    chk("rst.dout_comma", 32'(dout_comma), 32'h0);
    chk("rst.locked", 32'(locked), 32'h0);
    chk("rst.offset", 32'(offset), 32'h0);
    rst_n = 1'b1;
    k_sh  = k;
    last  = 10'h305;
    cm    = 10'h0FA;
  endtask

  task automatic add(input logic [9:0] sym, input logic vld, input logic lk, input logic [3:0] off,
                     input logic dv, input logic dc, input logic cd, input logic [9:0] d);
    vec_t v;
    v.sym = sym; v.vld = vld; v.exp_lk = lk; v.exp_off = off;
    v.exp_dv = dv; v.exp_dc = dc; v.chk_dout = cd; v.exp_dout = d;
    tbl.push_back(v);
  endtask

  task automatic run_tbl(input int first, input int lst);
    for (int i = first; i <= lst; i++) begin
      send(tbl[i].sym, tbl[i].vld);
      chk($sformatf("tbl%0d.locked", i), 32'(locked), 32'(tbl[i].exp_lk));
      chk($sformatf("tbl%0d.offset", i), 32'(offset), 32'(tbl[i].exp_off));
      chk($sformatf("tbl%0d.dout_valid", i), 32'(dout_valid), 32'(tbl[i].exp_dv));
      chk($sformatf("tbl%0d.dout_comma", i), 32'(dout_comma), 32'(tbl[i].exp_dc));
      if (tbl[i].chk_dout) chk($sformatf("tbl%0d.dout", i), 32'(dout), 32'(tbl[i].exp_dout));
    end
  endtask

  // Timeout scenario: two hits, n comma-free words, then commas
  task automatic verify_timeout(input int n, input string tag);
    logic seen;
    do_reset(5);
    send_comma();
    send_comma();
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      send(man(frame_byte(i)), 1'b1);
      seen = seen | locked;
    end
    chk({tag, ".never_locked"}, 32'(seen), 32'h0);
  endtask

  initial begin
    logic seen;

    // Idle comma stream at slip 3, from reset
    add(10'h0FA, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 10'h000);
    add(10'h305, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000);
    add(10'h0FA, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 10'h305);
    add(10'h305, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 10'h0FA);
    add(10'h0FA, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 10'h305);
    add(10'h305, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 10'h0FA);
    add(10'h0FA, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 10'h305);
    add(10'h305, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 10'h0FA);
    // rx_valid toggling during lock-up at slip 2 (indices 8..20)
    add(10'h0FA, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000);
    add(10'h0FA, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000);
    add(10'h305, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000);
    add(10'h0FA, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000);
    add(10'h0FA, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000);
    add(10'h0FA, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000);
    add(10'h305, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000);
    add(10'h0FA, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 10'h000);
    add(10'h0FA, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 10'h305);
    add(10'h0FA, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 10'h305);
    add(10'h305, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 10'h0FA);
    add(10'h0FA, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 10'h0FA);
    add(10'h0FA, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 10'h305);

    // Lock on idle commas
    do_reset(3);
    run_tbl(0, 7);

    // 125-word frame: lock holds, symbols come out in order
    for (int i = 0; i < 125; i++) begin
      send(man(frame_byte(i)), 1'b1);
      chk($sformatf("frame%0d.locked", i), 32'(locked), 32'h1);
      chk($sformatf("frame%0d.offset", i), 32'(offset), 32'h3);
      chk($sformatf("frame%0d.dout_valid", i), 32'(dout_valid), 32'h1);
      chk($sformatf("frame%0d.dout", i), 32'(dout), 32'(det));
      chk($sformatf("frame%0d.dout_comma", i), 32'(dout_comma), 32'(is_comma(det)));
    end

    // Stream slips from offset 3 to 7
    k_sh = 7;
    send(man(8'h55), 1'b1);
    send(man(8'h2A), 1'b1);
    chk("slip.still_locked", 32'(locked), 32'h1);
    send_comma();
    send_comma();
    send_comma();
    chk("slip.two_misses_locked", 32'(locked), 32'h1);
    send_comma();
    chk("slip.third_miss_unlock", 32'(locked), 32'h0);
    chk("slip.offset_kept", 32'(offset), 32'h3);
    send_comma();
    send_comma();
    send_comma();
    chk("slip.three_hits_unlocked", 32'(locked), 32'h0);
    send_comma();
    chk("slip.relock", 32'(locked), 32'h1);
    chk("slip.relock_offset", 32'(offset), 32'h7);
    send_comma();
    chk("slip.dout_valid", 32'(dout_valid), 32'h1);
    chk("slip.dout", 32'(dout), 32'(det));
    chk("slip.dout_comma", 32'(dout_comma), 32'h1);

    // 255 comma-free words in VERIFY: back to HUNT, needs 4 fresh commas
    verify_timeout(255, "tmo255");
    send_comma();
    send_comma();
    send_comma();
    chk("tmo255.no_stale_lock", 32'(locked), 32'h0);
    send_comma();
    chk("tmo255.three_hits", 32'(locked), 32'h0);
    send_comma();
    chk("tmo255.relock", 32'(locked), 32'h1);
    chk("tmo255.offset", 32'(offset), 32'h5);

    // 254 comma-free words: still in VERIFY, two more hits lock
    verify_timeout(254, "tmo254");
    send_comma();
    send_comma();
    chk("tmo254.three_hits", 32'(locked), 32'h0);
    send_comma();
    chk("tmo254.lock", 32'(locked), 32'h1);
    chk("tmo254.offset", 32'(offset), 32'h5);

    // rx_valid gaps during lock-up
    do_reset(2);
    run_tbl(8, 20);

    // Async reset mid-frame while locked, then relock at a new slip
    do_reset(3);
    for (int i = 0; i < 5; i++) send_comma();
    for (int i = 0; i < 3; i++) send(man(frame_byte(i)), 1'b1);
    chk("arst.pre_locked", 32'(locked), 32'h1);
    #20;
    rst_n = 1'b0;
    #1;
    chk("arst.dout", 32'(dout), 32'h0);
    chk("arst.dout_valid", 32'(dout_valid), 32'h0);
    chk("arst.dout_comma", 32'(dout_comma), 32'h0);
    chk("arst.locked", 32'(locked), 32'h0);
    chk("arst.offset", 32'(offset), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k_sh  = 6;
    last  = 10'h305;
    cm    = 10'h0FA;
    seen  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_comma();
      seen = seen | locked;
    end
    chk("arst.no_early_lock", 32'(seen), 32'h0);
    send_comma();
    chk("arst.relock", 32'(locked), 32'h1);
    chk("arst.relock_offset", 32'(offset), 32'h6);
    send_comma();
    chk("arst.dout", 32'(dout), 32'(det));
    chk("arst.dout_comma", 32'(dout_comma), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
